// File: rtl/digit_scan_if.sv
// Scan-controller handshake: start/stop/mask in, decoder select/enable and status out.
interface digit_scan_if;
  logic       start;
  logic       stop;
  logic [3:0] digit_mask;
  logic [1:0] sel;
  logic       en;
  logic       digit_strobe;
  logic       busy;

  modport master (
    output start, stop, digit_mask,
    input  sel, en, digit_strobe, busy
  );

  modport slave (
    input  start, stop, digit_mask,
    output sel, en, digit_strobe, busy
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-position scan controller driving a 2-to-4 decoder (sel/en).
// Optional macro SCAN_BLANK_EN inserts a BLANK_CYCLES enable-low gap between positions.
module digit_scan_ctrl #(
  parameter int DIV          = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  digit_scan_if.slave  bus
);

  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DIV - 1);

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;
`else
  typedef enum logic [0:0] {IDLE, DWELL} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             mask_any;

  assign mask_any = |bus.digit_mask;

  // Nearest set mask bit strictly above cur, wrapping; falls back to cur itself.
  function automatic logic [1:0] next_pos(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] idx;
    next_pos = cur;
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (mask[idx]) next_pos = idx;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      en_q     <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && mask_any) begin
          state_d = DWELL;
          cnt_d   = '0;
        end
      end
      DWELL: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
`ifdef SCAN_BLANK_EN
          state_d = BLANK;
`else
          state_d = mask_any ? DWELL : IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = mask_any ? DWELL : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new position begins whenever DWELL is entered from elsewhere or re-entered at its last cycle.
  always_comb begin
    en_d     = (state_d == DWELL);
    busy_d   = (state_d != IDLE);
    strobe_d = (state_d == DWELL) && ((state_q != DWELL) || (cnt_q == DWELL_LAST));
    sel_d    = sel_q;
    if (strobe_d)
      sel_d = next_pos(bus.digit_mask, (state_q == IDLE) ? 2'd3 : sel_q);
  end

  assign bus.sel          = sel_q;
  assign bus.en           = en_q;
  assign bus.digit_strobe = strobe_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Time-multiplexing scan controller that generates the 2-bit select and enable for the downstream 2-to-4 decoder. It steps through the four decoder outputs (e.g. display digit anodes) with a programmable dwell time, skips masked-off positions and inserts a blanking gap between positions. `sel` connects to the decoder's `in` port and `en` connects to the decoder's `en` port.

Parameters:
- DIV, 4: clock cycles `en` stays high per position; legal range >= 1.
- BLANK_CYCLES, 2: clock cycles `en` stays low between positions; legal range >= 1; used only when the optional feature is compiled in.

Ports:
- clk, input, 1: single system clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: level/pulse; begins scanning when sampled high in IDLE.
- stop, input, 1: aborts scanning on the next edge.
- digit_mask, input, 4: bit k = 1 means position k is scanned.
- sel, output, 2: current position index, drives the decoder's `in`.
- en, output, 1: decoder enable, high only during a dwell.
- digit_strobe, output, 1: one-cycle pulse on the first cycle of each dwell.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset (`rst_n` low, asynchronous, no clock needed):
  - state = IDLE; `sel` = 0, `en` = 0, `digit_strobe` = 0, `busy` = 0.
  - Dwell/blank counter = 0; counter width is $clog2 of the larger of DIV and BLANK_CYCLES, minimum 1 bit.
- States: IDLE, DWELL, BLANK (BLANK exists only with the feature).
- IDLE:
  - `start` = 1, `stop` = 0 and `digit_mask` != 0 go to DWELL on the next edge.
  - On entry, `sel` = lowest-index set bit of `digit_mask`, `en` = 1, `digit_strobe` = 1.
  - If `digit_mask` = 0, `start` is ignored and the block stays in IDLE.
  - In IDLE, `sel` holds its last value.
- DWELL:
  - `en` = 1; the counter runs 0..DIV-1.
  - On the cycle the counter = DIV-1 (the advance point), the next state is chosen:
    - with the feature: BLANK, with `en` = 0 from the next cycle;
    - without the feature: the next DWELL directly; `en` stays 1, `sel` changes and `digit_strobe` pulses.
  - `en` is high for exactly DIV consecutive cycles per position.
- BLANK:
  - `en` = 0 for exactly BLANK_CYCLES cycles; `sel` holds the old value throughout.
  - On the last blank cycle, go to DWELL with the next position.
- Next position:
  - The next set bit of `digit_mask` above the current `sel`, wrapping from 3 to 0; it may equal the current `sel` if only one bit is set.
  - `digit_mask` is sampled only at the advance point (end of DWELL without the feature, last BLANK cycle with it).
  - A bit cleared mid-dwell does not shorten the current dwell.
  - If `digit_mask` = 0 at the sampling point, go to IDLE (`en` = 0, `busy` = 0).
- `digit_strobe`: high exactly on the first DWELL cycle of every position, including repeats of the same position; low otherwise.
- `stop`:
  - Sampled high in any non-IDLE state, it forces IDLE on the next edge: `en` = 0, `digit_strobe` = 0, `busy` = 0, counter cleared, `sel` held.
  - `start` and `stop` high together: `stop` wins, state stays or goes IDLE.
  - `start` while busy is ignored.
- Restart after stop always begins at the lowest set bit, not at the held `sel`.
- Period per position: DIV + BLANK_CYCLES cycles with the feature, DIV cycles without it.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: the BLANK state and the BLANK_CYCLES gap are implemented as described above, which prevents ghosting between adjacent positions.
- Undefined:
  - No BLANK state exists and BLANK_CYCLES is unused.
  - `en` stays continuously high from start until stop or mask-empty.
  - `sel` changes on the cycle after the advance point.

Test Plan:
All cases use DIV = 4, BLANK_CYCLES = 2, SCAN_BLANK_EN defined unless stated.
1. Reset: assert `rst_n` = 0 between clock edges -> `sel` = 00, `en` = 0, `digit_strobe` = 0 and `busy` = 0 immediately; they stay there for 3 clocks after release with `start` = 0.
2. Full scan: `digit_mask` = 1111, `start` pulsed 1 cycle -> `sel` sequence 0,1,2,3,0; each with `en` high 4 cycles then low 2; 5 `digit_strobe` pulses 6 cycles apart; `busy` = 1 throughout.
3. Sparse mask: `digit_mask` = 1010, start -> `sel` 1,3,1,3. Then change mask to 0100 mid-dwell on position 3 -> position 3 completes 4 cycles, then `sel` = 2 repeatedly with a strobe every 6 cycles.
4. Empty mask:
   - `digit_mask` = 0000 with `start` = 1 -> `busy` stays 0, `en` stays 0.
   - Clearing the mask during a scan -> IDLE at the next advance point.
5. Stop:
   - `stop` on the 2nd dwell cycle of `sel` = 2 -> next edge `en` = 0, `busy` = 0, `sel` = 2.
   - `start` and `stop` in the same cycle -> stays IDLE.
   - Restart with mask 1111 -> `sel` = 0 first.
6. Async reset mid-DWELL and feature off:
   - `rst_n` low mid-DWELL -> outputs 0 without a clock edge.
   - Rebuild without SCAN_BLANK_EN, mask 1111 -> `en` continuously 1 and `sel` changes every 4 cycles.
